// File: rtl/aes_key_schedule.sv
// AES key-expansion engine for 128/192/256-bit keys: one schedule word per clock, random-access
// round-key read. Define AES_KEYSCHED_RDREG_EN to register rd_key (one-cycle read latency).
module aes_key_schedule #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] rx_key,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key,
    output logic [KEY_BITS-1:0] orig_key,
    output logic                busy,
    output logic                keys_ready
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned CW = 6;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    // Entry 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       i_q, i_d;
    logic [3:0]          j_q, j_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [31:0]         w_q [NW];
    logic [31:0]         w_d [NW];

    logic [31:0] prev_w, far_w, sub_in, sub_w, t_w;

    // j_q tracks i mod NK; rcon_q holds Rcon[i/NK] for the next multiple of NK.
    always_comb begin
        prev_w = w_q[i_q - CW'(1)];
        far_w  = w_q[i_q - CW'(NK)];
        sub_in = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_w  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        if (j_q == 4'd0) begin
            t_w = sub_w ^ {rcon_q, 24'h0};
        end else if (NK == 8 && j_q == 4'd4) begin
            t_w = sub_w;
        end else begin
            t_w = prev_w;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        key_d   = key_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        w_d     = w_q;
        if (key_load) begin
            for (int k = 0; k < NK; k++) begin
                w_d[k] = rx_key[KEY_BITS-1-32*k -: 32];
            end
            key_d   = rx_key;
            i_d     = CW'(NK);
            j_d     = 4'd0;
            rcon_d  = 8'h01;
            state_d = StExpand;
            busy_d  = 1'b1;
            ready_d = 1'b0;
        end else if (state_q == StExpand) begin
            w_d[i_q] = far_w ^ t_w;
            i_d      = i_q + CW'(1);
            j_d      = (j_q == 4'(NK - 1)) ? 4'd0 : j_q + 4'd1;
            if (j_q == 4'd0) begin
                rcon_d = xtime(rcon_q);
            end
            if (i_q == CW'(NW - 1)) begin
                state_d = StReady;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= 8'h01;
            key_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            w_q     <= w_d;
        end
    end

    logic [CW-1:0] base;
    logic [127:0]  rd_comb;

    always_comb begin
        base    = {rd_round, 2'b00};
        rd_comb = '0;
        if (rd_round <= 4'(NR)) begin
            rd_comb = {w_q[base], w_q[base + CW'(1)], w_q[base + CW'(2)], w_q[base + CW'(3)]};
        end
    end

`ifdef AES_KEYSCHED_RDREG_EN
    logic [127:0] rd_q, rd_d;

    always_comb begin
        rd_d = rd_comb;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_key = rd_q;
`else
    assign rd_key = rd_comb;
`endif

    assign orig_key   = key_q;
    assign busy       = busy_q;
    assign keys_ready = ready_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Parametrised AES key-expansion engine; successor to the fixed 128-bit round-key generator.
- Supports 128/192/256-bit keys.
- Generates one 32-bit schedule word per clock into an internal word store.
- Serves any round key by random-access read, so the cipher core no longer steps keys in lockstep with the round counter.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256; other values are a compile-time error.
- NK (localparam), KEY_BITS/32, key words: 4, 6 or 8.
- NR (localparam), NK+6, number of rounds: 10, 12 or 14.
- NW (localparam), 4*(NR+1), total schedule words: 44, 52 or 60.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- key_load  in  1  one-cycle strobe; capture rx_key and start expansion.
- rx_key  in  KEY_BITS  cipher key; MS byte is key byte 0.
- rd_round  in  4  round-key index to read, 0..NR.
- rd_key  out  128  round key rd_round.
- orig_key  out  KEY_BITS  copy of the last captured key.
- busy  out  1  expansion in progress.
- keys_ready  out  1  full schedule valid for the currently held key.

Behaviour:
- Reset (n_rst=0, async): all NW words=0, orig_key=0, busy=0, keys_ready=0, word counter=0.
- Word layout:
  - w[j] = rx_key[KEY_BITS-1-32j -: 32] for j<NK.
  - Round key r = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in bits 127:96.
- Load edge E0 (key_load=1):
  - w[0..NK-1] and orig_key are written.
  - Counter i=NK; busy=1, keys_ready=0 after E0.
- Generation edges E1..E(NW-NK): one word per edge, w[i] = w[i-NK] ^ t, where with p = w[i-1]:
  - i mod NK == 0: t = SubWord(RotWord(p)) ^ {Rcon[i/NK],24'h0}.
  - NK==8 and i mod NK == 4: t = SubWord(p).
  - otherwise: t = p.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- SubWord: four combinational S-box ROM instances inside the block.
- Completion at edge E(NW-NK): last word written; busy=0 and keys_ready=1 after that edge.
  - Latency from E0 to keys_ready: 40 / 46 / 52 cycles for 128 / 192 / 256.
- States: IDLE (busy=0, keys_ready=0), EXPAND, READY.
  - IDLE --key_load--> EXPAND
  - EXPAND --last word--> READY
  - READY --key_load--> EXPAND
- key_load during EXPAND: restart from E0 with the new key. keys_ready stays 0; no stale words from the old key are used after the restart.
- key_load in READY: keys_ready=0 after that edge; re-expansion proceeds.
- rx_key is sampled only on the load edge; later changes are ignored.
- Read port: rd_key is combinational from the store.
  - rd_round > NR returns 128'h0.
  - Reads during EXPAND return current store contents; they are valid only once keys_ready=1.
- Reset asserted mid-expansion: everything clears immediately; the next key_load restarts cleanly.

Optional Feature:
- Macro: AES_KEYSCHED_RDREG_EN.
- Defined: rd_key is registered.
  - Value reflects rd_round sampled at the previous edge (1-cycle read latency).
  - Reset value 0.
  - Out-of-range index registers 0.
- Undefined: rd_key is combinational, zero latency.
- Expansion timing and all other outputs are identical in both builds.

Test Plan:
- KEY_BITS=128, rx_key=2b7e151628aed2a6abf7158809cf4f3c, single load:
  - keys_ready rises 40 cycles after the load edge.
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=0 -> key.
  - orig_key = key.
- KEY_BITS=128, rx_key=68656c6c6f3030303030303030303030:
  - rd_round=1 -> 6d616868025158583261686802515858.
  - rd_round=10 -> 0043de6459c9e24b5a4ebb8add080009.
  - Random-order reads 10,1,5 return stable values.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - ready after 46 cycles.
  - rd_round=12 -> e98ba06f448c773c8ecc720401002202.
  - rd_round=13 -> 0.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - ready after 52 cycles.
  - rd_round=14 -> fe4890d1e6188d0b046df344706c631e.
- Restart: load key A, pulse key_load with key B 10 cycles later:
  - keys_ready stays 0 until 40 cycles after the second load.
  - Round keys match key B vectors.
  - orig_key = B.
- Reset during EXPAND (cycle 20):
  - busy/keys_ready/orig_key go 0 without waiting for a clock edge.
  - All rd_round reads return 0.
  - Reload completes normally.
  - Under AES_KEYSCHED_RDREG_EN, rd_key lags rd_round by exactly one cycle.
